// File: rtl/car_pkg.sv
// Shared encodings for the car mode controller: mode values and FSM states.
package car_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_SEMI   = 2'b10;
  localparam logic [1:0] MODE_AUTO   = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ARMING,
    ST_ON,
    ST_WAIT_RELEASE
  } state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a vector debouncer.
// The output follows the input only after DEBOUNCE_CYCLES identical samples.
module debouncer #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;

  // r_cnt holds how many identical samples differing from r_out have been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 == r_out) begin
        r_cnt <= '0;
      end else if (r_sync2 != r_prev) begin
        r_cnt <= CW'(1);
      end else if (r_cnt == CNT_LAST) begin
        r_out <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_dout = r_out;

endmodule

// File: rtl/mode_controller.sv
// Car power / drive-mode controller: debounced inputs, hold-to-power-on,
// press-to-power-off, and brake-qualified mode selection.
module mode_controller
  import car_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic [1:0] mode_selection,
  input  logic       brake,
  output logic [1:0] mode,
  output logic       powered,
  output logic       mode_changed
);

  localparam int HW = ($clog2(HOLD_CYCLES) < 1) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic       w_pwr;
  logic [1:0] w_sel;
  logic       w_brake;
  logic       w_pwr_rise;
  logic       w_mode_req;

  state_t        r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [1:0]    r_mode;
  logic          r_powered;
  logic          r_mode_changed;
  logic          r_pwr_prev;
  logic          r_off_pend;

  debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_power (
    .clk(clk), .rst(rst), .i_din(power), .o_dout(w_pwr)
  );

  debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .i_din(mode_selection), .o_dout(w_sel)
  );

  debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
    .clk(clk), .rst(rst), .i_din(brake), .o_dout(w_brake)
  );

  assign w_pwr_rise = w_pwr & ~r_pwr_prev;
  assign w_mode_req = w_brake && (w_sel != MODE_OFF) && (w_sel != r_mode);

  // A change right after another mode_changed pulse is deferred one cycle so
  // the pulse is never two cycles wide; a pending power-off is remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_OFF;
      r_hold_cnt     <= '0;
      r_mode         <= MODE_OFF;
      r_powered      <= 1'b0;
      r_mode_changed <= 1'b0;
      r_pwr_prev     <= 1'b0;
      r_off_pend     <= 1'b0;
    end else begin
      r_pwr_prev     <= w_pwr;
      r_mode_changed <= 1'b0;
      case (r_state)
        ST_OFF: begin
          r_hold_cnt <= '0;
          r_off_pend <= 1'b0;
          if (w_pwr) r_state <= ST_ARMING;
        end
        ST_ARMING: begin
          if (!w_pwr) begin
            r_state    <= ST_OFF;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state        <= ST_WAIT_RELEASE;
            r_hold_cnt     <= '0;
            r_powered      <= 1'b1;
            r_mode         <= (w_sel != MODE_OFF) ? w_sel : MODE_MANUAL;
            r_mode_changed <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_ON, ST_WAIT_RELEASE: begin
          if ((r_state == ST_ON) && (w_pwr_rise || r_off_pend)) begin
            if (r_mode_changed) begin
              r_off_pend <= 1'b1;
            end else begin
              r_state        <= ST_OFF;
              r_mode         <= MODE_OFF;
              r_powered      <= 1'b0;
              r_mode_changed <= 1'b1;
              r_off_pend     <= 1'b0;
            end
          end else begin
            if ((r_state == ST_WAIT_RELEASE) && !w_pwr) r_state <= ST_ON;
            if (w_mode_req && !r_mode_changed) begin
              r_mode         <= w_sel;
              r_mode_changed <= 1'b1;
            end
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign mode         = r_mode;
  assign powered      = r_powered;
  assign mode_changed = r_mode_changed;

endmodule
